// File: rtl/morse_keyer.sv
// Morse symbol sequencer: accepts dot/dash/gap codes and keys MARK/SPACE for whole unit times.
// Optional 4-entry input FIFO is enabled with `define MORSE_KEYER_FIFO_EN.
module morse_keyer #(
  parameter int UNIT_DIV = 25000000,
  parameter int CNT_W    = 32
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_code,
  output logic       sym_ready,
  output logic       key_out,
  output logic       unit_tick,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       units;
  logic             start;
  logic [1:0]       start_code;

`ifdef MORSE_KEYER_FIFO_EN
  logic [1:0] fifo_mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] fifo_cnt;
  logic       push;
  logic       pop;

  assign sym_ready  = (fifo_cnt != 3'd4);
  assign push       = sym_valid && sym_ready;
  assign pop        = (state == IDLE) && (fifo_cnt != 3'd0);
  assign start      = pop;
  assign start_code = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE) || (fifo_cnt != 3'd0);

  always_ff @(posedge in_clk) begin
    if (push) fifo_mem[wr_ptr] <= sym_code;
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign sym_ready  = (state == IDLE);
  assign start      = sym_valid && sym_ready;
  assign start_code = sym_code;
  assign busy       = (state != IDLE);
`endif

  assign unit_tick = (state != IDLE) && (count == LAST);

  // Prescaler sits at 0 in IDLE, so every symbol's first unit is a full UNIT_DIV cycles.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      units   <= 3'd0;
      key_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count   <= '0;
          key_out <= 1'b0;
          if (start) begin
            case (start_code)
              2'b00: begin state <= MARK;  units <= 3'd1; key_out <= 1'b1; end
              2'b01: begin state <= MARK;  units <= 3'd3; key_out <= 1'b1; end
              2'b10: begin state <= SPACE; units <= 3'd2; end
              default: begin state <= SPACE; units <= 3'd6; end
            endcase
          end
        end
        MARK, SPACE: begin
          count <= (count == LAST) ? '0 : count + CNT_W'(1);
          if (unit_tick) begin
            if (units == 3'd1) begin
              if (state == MARK) begin
                state   <= SPACE;
                units   <= 3'd1;
                key_out <= 1'b0;
              end else begin
                state <= IDLE;
                units <= 3'd0;
              end
            end else begin
              units <= units - 3'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          count   <= '0;
          units   <= 3'd0;
          key_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
